// File: rtl/cr_kme_drbg_seed_mgr_pkg.sv
// Shared types and widths for the DRBG seed manager slice.
package cr_kmePKG;

    localparam int DRBG_KEY_W = 256;
    localparam int DRBG_VAL_W = 128;
    localparam int DRBG_CNT_W = 48;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SELECT   = 2'd1,
        GRANT    = 2'd2,
        WAIT_UPD = 2'd3
    } drbg_seed_mgr_state_e;

endpackage

// File: rtl/cr_kme_drbg_seed_mgr_slot.sv
// One seed slot: valid-edge reload, working key/value, generate counter
// and the reseed-interval expiry compare.
module cr_kme_drbg_seed_slot
    import cr_kmePKG::*;
#(
    parameter int KEY_W = DRBG_KEY_W,
    parameter int VAL_W = DRBG_VAL_W,
    parameter int CNT_W = DRBG_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_valid,
    input  logic [KEY_W-1:0] init_key,
    input  logic [VAL_W-1:0] init_value,
    input  logic [CNT_W-1:0] reseed_interval,
    input  logic             grant,
    input  logic             upd_en,
    input  logic [KEY_W-1:0] upd_key,
    input  logic [VAL_W-1:0] upd_value,
    input  logic             clear,
    output logic             loaded,
    output logic             expired,
    output logic [KEY_W-1:0] key,
    output logic [VAL_W-1:0] value
);

    logic             valid_prev;
    logic             valid_rise;
    logic [CNT_W-1:0] count;

    assign valid_rise = seed_valid & ~valid_prev;

    // A zero interval means the seed never expires.
    assign expired = loaded && (reseed_interval != '0) && (count >= reseed_interval);

    // Slot state: a fresh valid edge reloads and beats any in-flight update;
    // dropping valid unloads the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_prev <= 1'b0;
            loaded     <= 1'b0;
            count      <= '0;
            key        <= '0;
            value      <= '0;
        end else begin
            valid_prev <= seed_valid;
            if (!seed_valid) begin
                loaded <= 1'b0;
            end else if (valid_rise) begin
                key    <= init_key;
                value  <= init_value;
                count  <= '0;
                loaded <= 1'b1;
            end else begin
                if (grant && (count != '1)) begin
                    count <= count + CNT_W'(1);
                end
                if (upd_en && loaded) begin
                    key   <= upd_key;
                    value <= upd_value;
                end
                if (clear) begin
                    loaded <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/cr_kme_drbg_seed_mgr.sv
// DRBG seed manager: picks a loaded seed slot, grants its working state to
// the DRBG core, takes the updated state back and signals seed expiry.
module cr_kme_drbg_seed_mgr
    import cr_kmePKG::*;
#(
    parameter int KEY_W = DRBG_KEY_W,
    parameter int VAL_W = DRBG_VAL_W,
    parameter int CNT_W = DRBG_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed0_valid,
    input  logic [KEY_W-1:0] seed0_internal_state_key,
    input  logic [VAL_W-1:0] seed0_internal_state_value,
    input  logic [CNT_W-1:0] seed0_reseed_interval,
    input  logic             seed1_valid,
    input  logic [KEY_W-1:0] seed1_internal_state_key,
    input  logic [VAL_W-1:0] seed1_internal_state_value,
    input  logic [CNT_W-1:0] seed1_reseed_interval,
    output logic             seed0_invalidate,
    output logic             seed1_invalidate,
    input  logic             drbg_req,
    output logic             drbg_ack,
    output logic             drbg_no_seed,
    output logic             drbg_seed_id,
    output logic [KEY_W-1:0] drbg_key,
    output logic [VAL_W-1:0] drbg_value,
    input  logic             drbg_upd_valid,
    input  logic [KEY_W-1:0] drbg_upd_key,
    input  logic [VAL_W-1:0] drbg_upd_value
);

    drbg_seed_mgr_state_e state, state_next;

    logic             active_id, active_next, sel_id;
    logic [1:0]       seed_valid, loaded, expired;
    logic [1:0]       grant, upd_en, clear, invalidate;
    logic [KEY_W-1:0] slot_key   [2];
    logic [VAL_W-1:0] slot_value [2];

    logic             ack_next, no_seed_next, id_next;
    logic [KEY_W-1:0] key_next;
    logic [VAL_W-1:0] value_next;

    assign seed_valid       = {seed1_valid, seed0_valid};
    assign seed0_invalidate = invalidate[0];
    assign seed1_invalidate = invalidate[1];

    cr_kme_drbg_seed_slot #(.KEY_W(KEY_W), .VAL_W(VAL_W), .CNT_W(CNT_W)) u_slot0 (
        .clk             (clk),
        .rst             (rst),
        .seed_valid      (seed0_valid),
        .init_key        (seed0_internal_state_key),
        .init_value      (seed0_internal_state_value),
        .reseed_interval (seed0_reseed_interval),
        .grant           (grant[0]),
        .upd_en          (upd_en[0]),
        .upd_key         (drbg_upd_key),
        .upd_value       (drbg_upd_value),
        .clear           (clear[0]),
        .loaded          (loaded[0]),
        .expired         (expired[0]),
        .key             (slot_key[0]),
        .value           (slot_value[0])
    );

    cr_kme_drbg_seed_slot #(.KEY_W(KEY_W), .VAL_W(VAL_W), .CNT_W(CNT_W)) u_slot1 (
        .clk             (clk),
        .rst             (rst),
        .seed_valid      (seed1_valid),
        .init_key        (seed1_internal_state_key),
        .init_value      (seed1_internal_state_value),
        .reseed_interval (seed1_reseed_interval),
        .grant           (grant[1]),
        .upd_en          (upd_en[1]),
        .upd_key         (drbg_upd_key),
        .upd_value       (drbg_upd_value),
        .clear           (clear[1]),
        .loaded          (loaded[1]),
        .expired         (expired[1]),
        .key             (slot_key[1]),
        .value           (slot_value[1])
    );

    // Next-state, slot controls and the registered grant outputs.
    always_comb begin
        state_next   = state;
        active_next  = active_id;
        sel_id       = active_id;
        ack_next     = 1'b0;
        no_seed_next = 1'b0;
        id_next      = 1'b0;
        key_next     = '0;
        value_next   = '0;
        grant        = 2'b00;
        upd_en       = 2'b00;
        clear        = 2'b00;
        invalidate   = 2'b00;
        case (state)
            IDLE: begin
                // The ack cycle of a no-seed answer still sees req high.
                if (drbg_req && !drbg_ack) begin
                    state_next = SELECT;
                end
            end
            SELECT: begin
                if (loaded[active_id] || loaded[~active_id]) begin
                    sel_id      = loaded[active_id] ? active_id : ~active_id;
                    active_next = sel_id;
                    ack_next    = 1'b1;
                    id_next     = sel_id;
                    key_next    = slot_key[sel_id];
                    value_next  = slot_value[sel_id];
                    state_next  = GRANT;
                end else begin
                    ack_next     = 1'b1;
                    no_seed_next = 1'b1;
                    state_next   = IDLE;
                end
            end
            GRANT: begin
                grant[active_id] = 1'b1;
                state_next       = WAIT_UPD;
            end
            WAIT_UPD: begin
                if (drbg_upd_valid) begin
                    upd_en[active_id] = 1'b1;
                    if (expired[active_id] && seed_valid[active_id]) begin
                        invalidate[active_id] = 1'b1;
                        clear[active_id]      = 1'b1;
                    end
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, active seed and grant output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            active_id    <= 1'b0;
            drbg_ack     <= 1'b0;
            drbg_no_seed <= 1'b0;
            drbg_seed_id <= 1'b0;
            drbg_key     <= '0;
            drbg_value   <= '0;
        end else begin
            state        <= state_next;
            active_id    <= active_next;
            drbg_ack     <= ack_next;
            drbg_no_seed <= no_seed_next;
            drbg_seed_id <= id_next;
            drbg_key     <= key_next;
            drbg_value   <= value_next;
        end
    end

endmodule

// File: tb/tb_cr_kme_drbg_seed_mgr.sv
// Directed self-checking bench for the DRBG seed manager.
module tb_cr_kme_drbg_seed_mgr;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         seed0_valid = 1'b0, seed1_valid = 1'b0;
    logic [255:0] seed0_key = '0, seed1_key = '0;
    logic [127:0] seed0_value = '0, seed1_value = '0;
    logic [47:0]  seed0_interval = '0, seed1_interval = '0;
    logic         seed0_invalidate, seed1_invalidate;
    logic         drbg_req = 1'b0;
    logic         drbg_ack, drbg_no_seed, drbg_seed_id;
    logic [255:0] drbg_key;
    logic [127:0] drbg_value;
    logic         drbg_upd_valid = 1'b0;
    logic [255:0] drbg_upd_key = '0;
    logic [127:0] drbg_upd_value = '0;

    int check_count = 0;
    int pass_count  = 0;
    int inv0_count  = 0;
    int inv1_count  = 0;
    int both_inv    = 0;

    logic [255:0] exp_key;
    logic [255:0] new_key;
    int           lat;

    cr_kme_drbg_seed_mgr dut (
        .clk                        (clk),
        .rst                        (rst),
        .seed0_valid                (seed0_valid),
        .seed0_internal_state_key   (seed0_key),
        .seed0_internal_state_value (seed0_value),
        .seed0_reseed_interval      (seed0_interval),
        .seed1_valid                (seed1_valid),
        .seed1_internal_state_key   (seed1_key),
        .seed1_internal_state_value (seed1_value),
        .seed1_reseed_interval      (seed1_interval),
        .seed0_invalidate           (seed0_invalidate),
        .seed1_invalidate           (seed1_invalidate),
        .drbg_req                   (drbg_req),
        .drbg_ack                   (drbg_ack),
        .drbg_no_seed               (drbg_no_seed),
        .drbg_seed_id               (drbg_seed_id),
        .drbg_key                   (drbg_key),
        .drbg_value                 (drbg_value),
        .drbg_upd_valid             (drbg_upd_valid),
        .drbg_upd_key               (drbg_upd_key),
        .drbg_upd_value             (drbg_upd_value)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Count invalidate pulses and flag any simultaneous pair.
    always @(negedge clk) begin
        if (seed0_invalidate) inv0_count++;
        if (seed1_invalidate) inv1_count++;
        if (seed0_invalidate && seed1_invalidate) both_inv++;
    end

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        check_count++;
        if (got === exp) pass_count++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Drop both seeds, then present the new seed set so valid edges occur.
    task automatic applyStimulus(input logic v0, input logic [255:0] k0, input logic [47:0] i0,
                                 input logic v1, input logic [255:0] k1, input logic [47:0] i1);
        seed0_valid = 1'b0;
        seed1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        seed0_key = k0; seed0_value = k0[127:0]; seed0_interval = i0;
        seed1_key = k1; seed1_value = k1[127:0]; seed1_interval = i1;
        seed0_valid = v0;
        seed1_valid = v1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Raise req, wait (bounded) for the ack, check the granted state.
    task automatic expectGrant(input string tag, input logic exp_no_seed, input logic exp_id,
                               input logic [255:0] exp_k, output int latency);
        logic seen;
        seen = 1'b0;
        latency = 0;
        drbg_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (drbg_ack) begin
                seen = 1'b1;
                latency = c;
                break;
            end
        end
        drbg_req = 1'b0;
        checkOutput({tag, "_ack"}, {255'd0, seen}, 256'd1);
        checkOutput({tag, "_no_seed"}, {255'd0, drbg_no_seed}, {255'd0, exp_no_seed});
        checkOutput({tag, "_id"}, {255'd0, drbg_seed_id}, {255'd0, exp_id});
        checkOutput({tag, "_key"}, drbg_key, exp_k);
        checkOutput({tag, "_value"}, {128'd0, drbg_value}, {128'd0, exp_k[127:0]});
    endtask

    // Return the updated state one cycle into WAIT_UPD and check the invalidates.
    task automatic doUpdate(input string tag, input logic [255:0] k, input logic exp_inv0, input logic exp_inv1);
        @(posedge clk);
        #1;
        drbg_upd_valid = 1'b1;
        drbg_upd_key   = k;
        drbg_upd_value = k[127:0];
        #1;
        checkOutput({tag, "_inv0"}, {255'd0, seed0_invalidate}, {255'd0, exp_inv0});
        checkOutput({tag, "_inv1"}, {255'd0, seed1_invalidate}, {255'd0, exp_inv1});
        @(posedge clk);
        #1;
        drbg_upd_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ack", {255'd0, drbg_ack}, 256'd0);
        checkOutput("rst_no_seed", {255'd0, drbg_no_seed}, 256'd0);
        checkOutput("rst_id", {255'd0, drbg_seed_id}, 256'd0);
        checkOutput("rst_key", drbg_key, 256'd0);
        checkOutput("rst_value", {128'd0, drbg_value}, 256'd0);
        checkOutput("rst_inv", {254'd0, seed1_invalidate, seed0_invalidate}, 256'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // T1: seed0 only, interval 3
        applyStimulus(1'b1, 256'hA0A0_0001, 48'd3, 1'b0, 256'd0, 48'd0);
        expectGrant("t1_g1", 1'b0, 1'b0, 256'hA0A0_0001, lat);
        checkOutput("t1_latency", 256'(lat), 256'd2);
        doUpdate("t1_u1", 256'hB1, 1'b0, 1'b0);
        expectGrant("t1_g2", 1'b0, 1'b0, 256'hB1, lat);
        doUpdate("t1_u2", 256'hB2, 1'b0, 1'b0);
        expectGrant("t1_g3", 1'b0, 1'b0, 256'hB2, lat);
        doUpdate("t1_u3", 256'hB3, 1'b1, 1'b0);
        checkOutput("t1_inv0_count", 256'(inv0_count), 256'd1);
        expectGrant("t1_g4", 1'b1, 1'b0, 256'd0, lat);
        checkOutput("t1_nosd_latency", 256'(lat), 256'd2);

        // T2: both seeds, seed0 interval 1, switch to seed1 after expiry
        applyStimulus(1'b1, 256'hC200, 48'd1, 1'b1, 256'hC311, 48'd0);
        expectGrant("t2_g1", 1'b0, 1'b0, 256'hC200, lat);
        doUpdate("t2_u1", 256'hD1, 1'b1, 1'b0);
        expectGrant("t2_g2", 1'b0, 1'b1, 256'hC311, lat);
        doUpdate("t2_u2", 256'hD2, 1'b0, 1'b0);
        checkOutput("t2_inv0_count", 256'(inv0_count), 256'd2);

        // T3: updates carry forward on seed1, unlimited interval
        exp_key = 256'hD2;
        for (int i = 0; i < 100; i++) begin
            expectGrant("t3_g", 1'b0, 1'b1, exp_key, lat);
            new_key = 256'hE000_0000 + 256'(i);
            doUpdate("t3_u", new_key, 1'b0, 1'b0);
            exp_key = new_key;
        end
        // Update outside WAIT_UPD must be ignored
        drbg_upd_valid = 1'b1;
        drbg_upd_key   = 256'hBAD;
        drbg_upd_value = 128'hBAD;
        @(posedge clk);
        #1;
        drbg_upd_valid = 1'b0;
        expectGrant("t3_stray", 1'b0, 1'b1, exp_key, lat);
        doUpdate("t3_last", 256'hE1, 1'b0, 1'b0);
        checkOutput("t3_inv1_count", 256'(inv1_count), 256'd0);

        // T4: seed0 dropped during WAIT_UPD, next request goes to seed1
        applyStimulus(1'b1, 256'hF400, 48'd1, 1'b0, 256'd0, 48'd0);
        expectGrant("t4_g1", 1'b0, 1'b0, 256'hF400, lat);
        seed0_valid = 1'b0;
        doUpdate("t4_u1", 256'hF4F4, 1'b0, 1'b0);
        applyStimulus(1'b0, 256'd0, 48'd0, 1'b1, 256'hF511, 48'd0);
        expectGrant("t4_g2", 1'b0, 1'b1, 256'hF511, lat);
        doUpdate("t4_u2", 256'hF5F5, 1'b0, 1'b0);

        // T6: seed0 re-rise after expiry reloads and restarts the count
        applyStimulus(1'b1, 256'h6600, 48'd2, 1'b0, 256'd0, 48'd0);
        expectGrant("t6_g1", 1'b0, 1'b0, 256'h6600, lat);
        doUpdate("t6_u1", 256'h6601, 1'b0, 1'b0);
        expectGrant("t6_g2", 1'b0, 1'b0, 256'h6601, lat);
        doUpdate("t6_u2", 256'h6602, 1'b1, 1'b0);
        applyStimulus(1'b1, 256'h6600, 48'd2, 1'b0, 256'd0, 48'd0);
        expectGrant("t6_g3", 1'b0, 1'b0, 256'h6600, lat);
        doUpdate("t6_u3", 256'h6603, 1'b0, 1'b0);

        // T5: reset in WAIT_UPD with an update that would expire the seed
        expectGrant("t5_g1", 1'b0, 1'b0, 256'h6603, lat);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drbg_upd_valid = 1'b1;
        drbg_upd_key   = 256'h77;
        #1;
        checkOutput("t5_inv0", {255'd0, seed0_invalidate}, 256'd0);
        checkOutput("t5_ack", {255'd0, drbg_ack}, 256'd0);
        checkOutput("t5_key", drbg_key, 256'd0);
        drbg_upd_valid = 1'b0;
        seed0_valid = 1'b0;
        seed1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        expectGrant("t5_g2", 1'b1, 1'b0, 256'd0, lat);
        applyStimulus(1'b1, 256'h7700, 48'd0, 1'b0, 256'd0, 48'd0);
        expectGrant("t5_g3", 1'b0, 1'b0, 256'h7700, lat);
        doUpdate("t5_u3", 256'h7701, 1'b0, 1'b0);

        checkOutput("never_both_inv", 256'(both_inv), 256'd0);
        checkOutput("final_inv0_count", 256'(inv0_count), 256'd3);
        checkOutput("final_inv1_count", 256'(inv1_count), 256'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
